// File: rtl/cpu_control.sv
// Instruction register and sequencing FSM for a simple load/store-less CPU.
// It decodes MOV/MVN/ADD/CMP/AND and drives the datapath enables and mux selects, one state at a time.
module cpu_control (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [3:0]  vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);
    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // The IR can only be loaded while idle, so a running instruction never changes under itself.
    assign ir_d = (state_q == S_WAIT && load) ? in : ir_q;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op;
    logic [4:0] key;
    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign rm     = ir_q[2:0];
    assign key    = {opcode, op};

    logic is_mov_imm, is_mov_reg, is_mvn, is_add, is_cmp, is_and;
    assign is_mov_imm = (key == 5'b110_10);
    assign is_mov_reg = (key == 5'b110_00);
    assign is_mvn     = (key == 5'b101_11);
    assign is_add     = (key == 5'b101_00);
    assign is_cmp     = (key == 5'b101_01);
    assign is_and     = (key == 5'b101_10);

    assign shift  = ir_q[4:3];
    assign ALUop  = op;
    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

    always_comb begin
        state_d  = state_q;
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 4'b0000;
        case (state_q)
            S_WAIT: begin
                w = 1'b1;
                if (s) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)                    state_d = S_WRITE_IMM;
                else if (is_mov_reg || is_mvn)     state_d = S_GET_B;
                else if (is_add || is_cmp || is_and) state_d = S_GET_A;
                else                               state_d = S_WAIT;
            end
            S_WRITE_IMM: begin
                writenum = rn;
                vsel     = 4'b0010;
                write    = 1'b1;
                state_d  = S_WAIT;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = S_GET_B;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = S_ALU;
            end
            S_ALU: begin
                // MOV reg passes B through by forcing the A operand to zero.
                loadc   = 1'b1;
                asel    = is_mov_reg;
                loads   = is_cmp;
                state_d = is_cmp ? S_WAIT : S_WRITE_REG;
            end
            S_WRITE_REG: begin
                writenum = rd;
                vsel     = 4'b1000;
                write    = 1'b1;
                state_d  = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end
endmodule
